// File: rtl/flasher_datapath.sv
// Counter/lamp datapath for the bound-flasher controller: saturating 4-bit
// counter with sticky bound errors, debounced button input and a thermometer lamp bar.
module flasher_datapath #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flick_raw,
  input  logic        enable,
  input  logic        upcount,
  input  logic        err_clr,
  output logic [3:0]  counter_val,
  output logic        flick,
  output logic [15:0] lamps,
  output logic        err_ovf,
  output logic        err_udf
);

  localparam logic [7:0] DC_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [3:0]  r_count;
  logic        r_err_ovf;
  logic        r_err_udf;
  logic        r_s1;
  logic        r_s2;
  logic        r_flick;
  logic [7:0]  r_dc;

  logic        w_at_max;
  logic        w_at_min;
  logic        w_ovf_set;
  logic        w_udf_set;
  logic [15:0] w_lamps;

  assign w_at_max  = (r_count == 4'd15);
  assign w_at_min  = (r_count == 4'd0);
  assign w_ovf_set = enable &  upcount & w_at_max;
  assign w_udf_set = enable & ~upcount & w_at_min;

  // Saturating counter; bound violations are only flagged, never wrapped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= 4'd0;
    end else if (enable) begin
      if (upcount && !w_at_max) begin
        r_count <= r_count + 4'd1;
      end else if (!upcount && !w_at_min) begin
        r_count <= r_count - 4'd1;
      end
    end
  end

  // A set condition in the same cycle as err_clr keeps the flag high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_err_ovf <= 1'b1;
      end else if (err_clr) begin
        r_err_ovf <= 1'b0;
      end
      if (w_udf_set) begin
        r_err_udf <= 1'b1;
      end else if (err_clr) begin
        r_err_udf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= flick_raw;
      r_s2 <= r_s1;
    end
  end

  // flick follows s2 only after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_flick <= 1'b0;
      r_dc    <= 8'd0;
    end else if (r_s2 == r_flick) begin
      r_dc <= 8'd0;
    end else if (r_dc == DC_LAST) begin
      r_flick <= r_s2;
      r_dc    <= 8'd0;
    end else begin
      r_dc <= r_dc + 8'd1;
    end
  end

  // Thermometer: the lowest counter_val lamps lit, so lamp 15 never lights.
  assign w_lamps = (16'd1 << r_count) - 16'd1;

  assign counter_val = r_count;
  assign lamps       = w_lamps;
  assign flick       = r_flick;
  assign err_ovf     = r_err_ovf;
  assign err_udf     = r_err_udf;

endmodule

// File: doc/flasher_datapath.md
# flasher_datapath

Counter/lamp datapath answering the bound-flasher control FSM. It consumes the FSM's `enable`/`upcount` commands and returns the registered 4-bit `counter_val` the FSM branches on. It conditions the raw `flick` button into a synchronized, debounced level for the FSM, and drives a 16-lamp thermometer bar. It sits between the board I/O (button, lamps) and the control FSM.

## Interface

- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before `flick` follows the synchronized input. Legal range 1..255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `flick_raw`  in  1  asynchronous button input.
- `enable`  in  1  count command from the FSM; 1 means step this cycle.
- `upcount`  in  1  direction from the FSM; 1 means +1, 0 means −1. Ignored when `enable`=0.
- `err_clr`  in  1  clears the sticky error flags.
- `counter_val`  out  4  registered count, 0..15, fed back to the FSM.
- `flick`  out  1  synchronized and debounced button level, registered.
- `lamps`  out  16  thermometer decode: `lamps[i]` = (i < `counter_val`).
- `err_ovf`  out  1  sticky flag: an up-step was commanded at 15.
- `err_udf`  out  1  sticky flag: a down-step was commanded at 0.

## Operation

- Reset (`reset_n`=0 at an edge) sets `counter_val`=0, `flick`=0, `err_ovf`=`err_udf`=0, both sync flops=0, debounce count=0. As a result `lamps`=16'h0000. Reset overrides all other inputs, including mid-count or mid-debounce.
- Counter behaviour at each edge:
  - `enable`=0: hold.
  - `enable`=1, `upcount`=1, value <15: +1.
  - `enable`=1, `upcount`=0, value >0: −1.
  - No wrap-around: at 15 an up command holds 15 and sets `err_ovf`; at 0 a down command holds 0 and sets `err_udf`.
- Error flags:
  - Flags are sticky until an edge with `err_clr`=1.
  - If a set condition and `err_clr` occur at the same edge, set wins and the flag stays 1.
  - Errors never alter counting.
- Lamps: purely combinational from the `counter_val` register. Values: 0 → 16'h0000, 5 → 16'h001F, 10 → 16'h03FF, 15 → 16'h7FFF. `lamps[15]` is never lit.
- Flick path:
  - Two-flop synchronizer `s1`→`s2`.
  - Debounce counter `dc`, 8 bits.
  - At each edge:
    - If `s2`==`flick`: `dc`←0.
    - Else if `dc`==`DEBOUNCE_CYCLES`−1: `flick`←`s2`, `dc`←0.
    - Else: `dc`←`dc`+1.
  - Any mismatch run shorter than `DEBOUNCE_CYCLES` is discarded.
- No combinational path from `enable`/`upcount` to `counter_val`. The FSM's next_state logic may therefore depend combinationally on `counter_val` without forming a loop.

## Timing

- Counter latency: a command sampled at edge k is visible on `counter_val` and `lamps` after edge k.
- Error latency: a flag rises after the edge that samples the illegal command.
- `flick` latency: `flick_raw` changes and is stable before edge 1. `s2` updates at edge 2. `flick` updates at edge `DEBOUNCE_CYCLES`+2 (6 with the default, 3 with `DEBOUNCE_CYCLES`=1).
- Glitch rejection: a pulse on `s2` lasting ≤ `DEBOUNCE_CYCLES`−1 cycles produces no `flick` change.
- Outputs are undefined only before the first reset edge. The bench must apply reset for at least 1 cycle.

## Test plan

- Reset during activity: hold `reset_n`=0 for 2 cycles with `enable`=1, `upcount`=1, `flick_raw`=1. Required: `counter_val`=0, `lamps`=0, `flick`=0, both errors 0. Then release and verify counting resumes from 0 → 1 on the first post-reset edge.
- Flasher sweep: drive up ×5, down ×5, up ×10, down ×5, up ×10, down ×14. Required: `counter_val` traces 0→5→0→10→5→15→1. `lamps`=16'h001F at 5 and 16'h7FFF at 15. No error flags.
- Bounds: at 15 command up for 2 cycles. Required: `counter_val` stays 15, `err_ovf`=1 after the first edge. Assert `err_clr` while up is still commanded: `err_ovf` stays 1. Drop `enable` and pulse `err_clr`: `err_ovf`=0. Mirror the test at 0 for `err_udf`.
- Debounce with `DEBOUNCE_CYCLES`=4:
  - `flick_raw` 0→1 held: `flick` rises exactly 6 edges later.
  - A 3-cycle high glitch: `flick` stays 0.
  - A 4-cycle high pulse: `flick` rises, then falls 4 cycles after `s2` falls.
- Enable-low hold: `enable`=0 for 8 cycles with `upcount` toggling. Required: `counter_val` unchanged, no error flags.
- Bounce during count: toggle `flick_raw` every cycle for 20 cycles while counting up. Required: `flick` stays 0, counting is unaffected.
